// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the sync FIFO family and its stream packetizer.
package fifo_pkg;

    localparam int unsigned PKT_DWIDTH_DEF  = 32'd32;
    localparam int unsigned PKT_MAX_LEN_DEF = 32'd64;
    localparam int unsigned PKT_TIMEOUT_DEF = 32'd256;

    // Why the held word left the hold register this cycle.
    typedef enum logic [1:0] {
        REL_NONE  = 2'd0,
        REL_LEN   = 2'd1,
        REL_DATA  = 2'd2,
        REL_FLUSH = 2'd3
    } rel_cause_e;

    // A requested length of 0 means single-beat packets; anything above the
    // maximum is limited to the maximum.
    function automatic int unsigned clamp_pkt_len(input int unsigned len,
                                                  input int unsigned max_len);
        int unsigned res;
        if (len == 32'd0) begin
            res = 32'd1;
        end else if (len > max_len) begin
            res = max_len;
        end else begin
            res = len;
        end
        return res;
    endfunction

    // Bits needed to hold a counter that counts up to max_val inclusive.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        int unsigned res;
        res = $clog2(max_val + 32'd1);
        if (res == 32'd0) begin
            res = 32'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/axis_out_reg.sv
// AXI4-Stream output register stage. A new beat may be loaded whenever the
// stage is free (empty, or its current beat is being accepted); otherwise the
// presented beat is held stable until the sink takes it.
module axis_out_reg #(
    parameter int DWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DWIDTH-1:0] load_data,
    input  logic              load_last,
    input  logic              tready,
    output logic [DWIDTH-1:0] tdata,
    output logic              tvalid,
    output logic              tlast,
    output logic              free
);

    logic load_ok_s;

    assign free      = !tvalid | tready;
    assign load_ok_s = load & free;

    // Output beat register: load when free, drop valid after acceptance, else hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tdata  <= {DWIDTH{1'b0}};
            tvalid <= 1'b0;
            tlast  <= 1'b0;
        end else if (load_ok_s) begin
            tdata  <= load_data;
            tvalid <= 1'b1;
            tlast  <= load_last;
        end else if (tready) begin
            tvalid <= 1'b0;
            tlast  <= 1'b0;
        end else begin
            tdata  <= tdata;
            tvalid <= tvalid;
            tlast  <= tlast;
        end
    end

endmodule

// File: rtl/fifo_axis_packetizer.sv
// Drains a first-word-fall-through FIFO into an AXI4-Stream master with tlast
// framing. One word is kept in a hold register so that a packet can always be
// closed on a real data beat: either the length-th beat of the packet, or the
// held word after the FIFO has stayed empty for TIMEOUT cycles.
module fifo_axis_packetizer
    import fifo_pkg::*;
#(
    parameter int DWIDTH      = PKT_DWIDTH_DEF,
    parameter int MAX_PKT_LEN = PKT_MAX_LEN_DEF,
    parameter int TIMEOUT     = PKT_TIMEOUT_DEF
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [DWIDTH-1:0]                  fifo_rd_data,
    input  logic                               fifo_rd_empty,
    output logic                               fifo_rd_en,
    input  logic [$clog2(MAX_PKT_LEN+1)-1:0]   cfg_pkt_len,
    output logic [DWIDTH-1:0]                  m_axis_tdata,
    output logic                               m_axis_tvalid,
    input  logic                               m_axis_tready,
    output logic                               m_axis_tlast,
    output logic                               pkt_done,
    output logic [31:0]                        stat_pkt_cnt,
    output logic [15:0]                        stat_flush_cnt
);

    localparam int LW = $clog2(MAX_PKT_LEN + 1);
    localparam int IW = cnt_width(TIMEOUT);

    localparam logic [IW-1:0] IDLE_LIMIT = IW'(TIMEOUT);
    localparam logic [IW-1:0] IDLE_ONE   = IW'(1'b1);
    localparam logic [LW-1:0] BEAT_ONE   = LW'(1'b1);
    localparam logic [LW-1:0] BEAT_ZERO  = {LW{1'b0}};

    // Hold stage
    logic [DWIDTH-1:0] hold_data_r;
    logic              hold_vld_r;

    // Packet framing state
    logic [LW-1:0]     beat_cnt_r;
    logic [LW-1:0]     beat_cnt_nxt_s;
    logic [LW-1:0]     pkt_len_r;
    logic [IW-1:0]     idle_cnt_r;

    // Statistics
    logic [31:0]       pkt_cnt_r;
    logic [15:0]       flush_cnt_r;
    logic              pkt_done_r;

    // Release decision
    logic              o_free_s;
    logic              len_hit_s;
    logic              timeout_hit_s;
    rel_cause_e        rel_cause_s;
    logic              release_s;
    logic              rel_last_s;
    logic              rel_flush_s;
    logic              load_h_s;
    logic              accept_last_s;

    assign len_hit_s     = ((beat_cnt_r + BEAT_ONE) == pkt_len_r);
    assign timeout_hit_s = (TIMEOUT != 32'sd0) && (idle_cnt_r == IDLE_LIMIT);

    // Pick why (if at all) the held word moves to the output stage; a
    // length-terminated packet wins over a pending flush.
    always_comb begin
        rel_cause_s = REL_NONE;
        if (hold_vld_r && o_free_s) begin
            if (len_hit_s) begin
                rel_cause_s = REL_LEN;
            end else if (!fifo_rd_empty) begin
                rel_cause_s = REL_DATA;
            end else if (timeout_hit_s) begin
                rel_cause_s = REL_FLUSH;
            end else begin
                rel_cause_s = REL_NONE;
            end
        end else begin
            rel_cause_s = REL_NONE;
        end
    end

    // Decode the release cause into the control strobes for the output stage.
    always_comb begin
        release_s   = 1'b0;
        rel_last_s  = 1'b0;
        rel_flush_s = 1'b0;
        case (rel_cause_s)
            REL_LEN: begin
                release_s  = 1'b1;
                rel_last_s = 1'b1;
            end
            REL_DATA: begin
                release_s  = 1'b1;
            end
            REL_FLUSH: begin
                release_s   = 1'b1;
                rel_last_s  = 1'b1;
                rel_flush_s = 1'b1;
            end
            default: begin
                release_s   = 1'b0;
                rel_last_s  = 1'b0;
                rel_flush_s = 1'b0;
            end
        endcase
    end

    // Pop only into an empty or simultaneously draining hold register; nothing is popped in reset.
    assign load_h_s   = !rst && !fifo_rd_empty && (!hold_vld_r || release_s);
    assign fifo_rd_en = load_h_s;

    assign accept_last_s = m_axis_tvalid && m_axis_tready && m_axis_tlast;

    // Beat position after this edge: a tlast release closes the packet.
    always_comb begin
        beat_cnt_nxt_s = beat_cnt_r;
        if (release_s) begin
            if (rel_last_s) begin
                beat_cnt_nxt_s = BEAT_ZERO;
            end else begin
                beat_cnt_nxt_s = beat_cnt_r + BEAT_ONE;
            end
        end else begin
            beat_cnt_nxt_s = beat_cnt_r;
        end
    end

    // Hold register: refill from the FIFO, or empty out when its word is released.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_data_r <= {DWIDTH{1'b0}};
            hold_vld_r  <= 1'b0;
        end else if (load_h_s) begin
            hold_data_r <= fifo_rd_data;
            hold_vld_r  <= 1'b1;
        end else if (release_s) begin
            hold_data_r <= hold_data_r;
            hold_vld_r  <= 1'b0;
        end else begin
            hold_data_r <= hold_data_r;
            hold_vld_r  <= hold_vld_r;
        end
    end

    // Beat counter within the current packet.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_cnt_r <= BEAT_ZERO;
        end else begin
            beat_cnt_r <= beat_cnt_nxt_s;
        end
    end

    // Latch the packet length when the first word of a new packet enters the
    // hold register, so mid-packet configuration changes apply to the next packet.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_len_r <= BEAT_ZERO;
        end else if (load_h_s && (beat_cnt_nxt_s == BEAT_ZERO)) begin
            pkt_len_r <= LW'(clamp_pkt_len(32'(cfg_pkt_len), 32'(MAX_PKT_LEN)));
        end else begin
            pkt_len_r <= pkt_len_r;
        end
    end

    // Idle timer for the held word; it stops at the limit while the output is blocked.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_cnt_r <= {IW{1'b0}};
        end else if (load_h_s || release_s) begin
            idle_cnt_r <= {IW{1'b0}};
        end else if (hold_vld_r && (idle_cnt_r != IDLE_LIMIT)) begin
            idle_cnt_r <= idle_cnt_r + IDLE_ONE;
        end else begin
            idle_cnt_r <= idle_cnt_r;
        end
    end

    // Packet counter (wrapping) and completion pulse on each accepted tlast beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_cnt_r  <= 32'd0;
            pkt_done_r <= 1'b0;
        end else if (accept_last_s) begin
            pkt_cnt_r  <= pkt_cnt_r + 32'd1;
            pkt_done_r <= 1'b1;
        end else begin
            pkt_cnt_r  <= pkt_cnt_r;
            pkt_done_r <= 1'b0;
        end
    end

    // Saturating count of packets closed by the idle timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flush_cnt_r <= 16'd0;
        end else if (rel_flush_s && (flush_cnt_r != 16'hFFFF)) begin
            flush_cnt_r <= flush_cnt_r + 16'd1;
        end else begin
            flush_cnt_r <= flush_cnt_r;
        end
    end

    axis_out_reg #(
        .DWIDTH (DWIDTH)
    ) u_out (
        .clk       (clk),
        .rst       (rst),
        .load      (release_s),
        .load_data (hold_data_r),
        .load_last (rel_last_s),
        .tready    (m_axis_tready),
        .tdata     (m_axis_tdata),
        .tvalid    (m_axis_tvalid),
        .tlast     (m_axis_tlast),
        .free      (o_free_s)
    );

    assign pkt_done       = pkt_done_r;
    assign stat_pkt_cnt   = pkt_cnt_r;
    assign stat_flush_cnt = flush_cnt_r;

endmodule

// File: tb/tb_fifo_axis_packetizer.sv
// Self-checking bench for fifo_axis_packetizer: a queue-based FIFO feeds the
// design, and a timestamp-based reference model predicts every output cycle.
module tb_fifo_axis_packetizer;

    localparam int DW   = 32;
    localparam int MAXL = 64;
    localparam int TO   = 16;
    localparam int LW   = $clog2(MAXL + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] fifo_rd_data;
    logic          fifo_rd_empty;
    logic          fifo_rd_en;
    logic [LW-1:0] cfg_pkt_len;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic          m_axis_tlast;
    logic          pkt_done;
    logic [31:0]   stat_pkt_cnt;
    logic [15:0]   stat_flush_cnt;

    always #5 clk = ~clk;

    fifo_axis_packetizer #(
        .DWIDTH      (DW),
        .MAX_PKT_LEN (MAXL),
        .TIMEOUT     (TO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .fifo_rd_data   (fifo_rd_data),
        .fifo_rd_empty  (fifo_rd_empty),
        .fifo_rd_en     (fifo_rd_en),
        .cfg_pkt_len    (cfg_pkt_len),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tready  (m_axis_tready),
        .m_axis_tlast   (m_axis_tlast),
        .pkt_done       (pkt_done),
        .stat_pkt_cnt   (stat_pkt_cnt),
        .stat_flush_cnt (stat_flush_cnt)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Upstream FIFO contents and the in-order scoreboard of pushed words
    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] sb_q[$];

    // Reference model: the held word carries its pop timestamp
    bit            m_h_has;
    logic [DW-1:0] m_h_data;
    int            m_h_pop;
    bit            m_o_valid;
    logic [DW-1:0] m_o_data;
    bit            m_o_last;
    int            m_beats;
    int            m_len;
    logic [31:0]   m_pkt_cnt;
    int            m_flush_cnt;
    bit            m_done;
    int            cyc = 0;

    // Stimulus controls
    bit tready_fixed = 1'b1;
    bit rand_ready   = 1'b0;

    // Log of beats accepted by the sink
    logic [DW-1:0] log_data[$];
    bit            log_last[$];
    int            log_cyc[$];
    int            last_pop_cyc = 0;
    int            done_seen = 0;

    // Previous-cycle stall snapshot for the AXI stability rule
    bit            prev_stall = 1'b0;
    logic [DW-1:0] prev_data;
    bit            prev_last;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int clamp_len(input int v);
        if (v == 0) return 1;
        if (v > MAXL) return MAXL;
        return v;
    endfunction

    task automatic model_reset();
        m_h_has = 1'b0; m_h_data = '0; m_h_pop = 0;
        m_o_valid = 1'b0; m_o_data = '0; m_o_last = 1'b0;
        m_beats = 0; m_len = 0; m_pkt_cnt = 32'd0; m_flush_cnt = 0; m_done = 1'b0;
        fifo_q.delete();
        sb_q.delete();
        prev_stall = 1'b0;
    endtask

    task automatic clear_log();
        log_data.delete(); log_last.delete(); log_cyc.delete();
        done_seen = 0;
    endtask

    task automatic push_words(input int n);
        logic [DW-1:0] w;
        for (int i = 0; i < n; i++) begin
            w = $urandom;
            fifo_q.push_back(w);
            sb_q.push_back(w);
        end
    endtask

    task automatic compare_outputs();
        check("tvalid", m_axis_tvalid, m_o_valid);
        if (m_o_valid) begin
            check("tdata", m_axis_tdata, m_o_data);
            check("tlast", m_axis_tlast, m_o_last);
        end
        if (prev_stall) begin
            check("axis_stable_data", m_axis_tdata, prev_data);
            check("axis_stable_last", m_axis_tlast, prev_last);
        end
        check("pkt_done", pkt_done, m_done);
        check("stat_pkt_cnt", stat_pkt_cnt, m_pkt_cnt);
        check("stat_flush_cnt", stat_flush_cnt, m_flush_cnt);
        if (pkt_done) done_seen++;
    endtask

    // One clock: drive inputs at negedge, predict the coming edge, check after it.
    task automatic step();
        bit empty, free, timeout, len_end, rel, last, flush, rd;
        m_axis_tready = rand_ready ? 1'($urandom_range(0, 1)) : tready_fixed;
        empty         = (fifo_q.size() == 0);
        fifo_rd_empty = empty;
        fifo_rd_data  = empty ? DW'($urandom) : fifo_q[0];
        #1;
        prev_stall = m_axis_tvalid && !m_axis_tready;
        prev_data  = m_axis_tdata;
        prev_last  = m_axis_tlast;
        if (m_axis_tvalid && m_axis_tready) begin
            log_data.push_back(m_axis_tdata);
            log_last.push_back(m_axis_tlast);
            log_cyc.push_back(cyc);
            check("order_avail", (sb_q.size() > 0), 1'b1);
            if (sb_q.size() > 0) check("order_data", m_axis_tdata, sb_q.pop_front());
        end
        free    = !m_o_valid || m_axis_tready;
        timeout = (TO != 0) && m_h_has && ((cyc - m_h_pop - 1) >= TO);
        len_end = (m_beats + 1 == m_len);
        rel     = m_h_has && free && (len_end || !empty || timeout);
        last    = len_end || (empty && timeout);
        flush   = rel && !len_end && empty && timeout;
        rd      = !empty && (!m_h_has || rel);
        check("fifo_rd_en", fifo_rd_en, rd);
        m_done = m_o_valid && m_axis_tready && m_o_last;
        if (m_done) m_pkt_cnt = m_pkt_cnt + 32'd1;
        if (rel) begin
            m_o_valid = 1'b1; m_o_data = m_h_data; m_o_last = last;
            m_beats = last ? 0 : m_beats + 1;
            if (flush && m_flush_cnt < 65535) m_flush_cnt++;
        end else if (m_axis_tready) begin
            m_o_valid = 1'b0;
        end
        if (rd) begin
            m_h_has = 1'b1; m_h_data = fifo_q.pop_front(); m_h_pop = cyc; last_pop_cyc = cyc;
            if (m_beats == 0) m_len = clamp_len(int'(cfg_pkt_len));
        end else if (rel) begin
            m_h_has = 1'b0;
        end
        cyc++;
        @(negedge clk);
        compare_outputs();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic run_until_beats(input int n, input int budget, input string name);
        int k = 0;
        while (log_data.size() < n && k < budget) begin
            step();
            k++;
        end
        check(name, (log_data.size() >= n), 1'b1);
    endtask

    function automatic int count_last();
        int c = 0;
        foreach (log_last[i]) if (log_last[i]) c++;
        return c;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pat;
        int pushed;
        rst = 1'b1;
        fifo_rd_empty = 1'b1;
        fifo_rd_data = '0;
        m_axis_tready = 1'b0;
        cfg_pkt_len = LW'(4);
        model_reset();
        repeat (2) @(negedge clk);
        check("reset_tvalid", m_axis_tvalid, 1'b0);
        check("reset_rd_en", fifo_rd_en, 1'b0);
        check("reset_pkt_cnt", stat_pkt_cnt, 32'd0);
        check("reset_flush_cnt", stat_flush_cnt, 16'd0);
        check("reset_pkt_done", pkt_done, 1'b0);
        rst = 1'b0;

        // 1: eight preloaded words, length 4, sink always ready
        cfg_pkt_len = LW'(4); tready_fixed = 1'b1; rand_ready = 1'b0;
        clear_log(); push_words(8);
        run_until_beats(8, 40, "t1_beats");
        run(2);
        pat = 8'd0;
        for (int i = 0; i < 8 && i < log_last.size(); i++) pat[i] = log_last[i];
        check("t1_tlast_pattern", pat, 8'b1000_1000);
        if (log_cyc.size() >= 8) check("t1_back_to_back", log_cyc[7] - log_cyc[0], 7);
        check("t1_pkt_done_pulses", done_seen, 2);
        check("t1_stat_pkt_cnt", stat_pkt_cnt, 32'd2);

        // 2: three words then idle, closed by the timeout
        clear_log(); push_words(3);
        run_until_beats(3, 60, "t2_beats");
        run(2);
        check("t2_tlast_count", count_last(), 1);
        if (log_last.size() >= 3) check("t2_third_is_last", log_last[2], 1'b1);
        if (log_cyc.size() >= 3) check("t2_flush_delay", log_cyc[2] - last_pop_cyc, TO + 2);
        check("t2_stat_flush_cnt", stat_flush_cnt, 16'd1);
        check("t2_stat_pkt_cnt", stat_pkt_cnt, 32'd3);

        // 4a: length 0 behaves as 1
        cfg_pkt_len = LW'(0);
        clear_log(); push_words(6);
        run_until_beats(6, 40, "t4a_beats");
        run(2);
        check("t4a_all_last", count_last(), 6);
        check("t4a_stat_pkt_cnt", stat_pkt_cnt, 32'd9);

        // 4b: widest request is clamped to MAXL beats; the tail is flushed
        cfg_pkt_len = LW'(127);
        clear_log(); push_words(130);
        run_until_beats(130, 400, "t4b_beats");
        run(2);
        check("t4b_tlast_count", count_last(), 3);
        if (log_last.size() >= 130) begin
            check("t4b_last_at_64", log_last[63], 1'b1);
            check("t4b_last_at_128", log_last[127], 1'b1);
            check("t4b_last_at_130", log_last[129], 1'b1);
        end
        check("t4b_stat_flush_cnt", stat_flush_cnt, 16'd2);

        // 5: length changes 4 -> 8 mid-packet
        cfg_pkt_len = LW'(4);
        clear_log(); push_words(2);
        run(3);
        cfg_pkt_len = LW'(8);
        push_words(14);
        run_until_beats(16, 100, "t5_beats");
        run(2);
        check("t5_tlast_count", count_last(), 3);
        if (log_last.size() >= 16) begin
            check("t5_first_pkt_4", log_last[3], 1'b1);
            check("t5_second_pkt_8", log_last[11], 1'b1);
            check("t5_tail_flush", log_last[15], 1'b1);
        end

        // 3: random back-pressure and random arrival gaps over 100 words
        cfg_pkt_len = LW'($urandom_range(1, 10));
        rand_ready = 1'b1;
        clear_log();
        pushed = 0;
        for (int k = 0; k < 3000 && log_data.size() < 100; k++) begin
            if (pushed < 100 && $urandom_range(0, 1) == 1) begin
                push_words(1);
                pushed++;
            end
            step();
        end
        check("t3_beats", log_data.size(), 100);
        rand_ready = 1'b0; tready_fixed = 1'b1;
        run(TO + 4);
        check("t3_sb_drained", sb_q.size(), 0);

        // 6: reset with hold and output registers both full
        cfg_pkt_len = LW'(4); tready_fixed = 1'b0;
        clear_log(); push_words(6);
        run(4);
        check("t6_stalled_valid", m_axis_tvalid, 1'b1);
        rst = 1'b1;
        #1;
        check("t6_rst_tvalid", m_axis_tvalid, 1'b0);
        check("t6_rst_pkt_cnt", stat_pkt_cnt, 32'd0);
        check("t6_rst_flush_cnt", stat_flush_cnt, 16'd0);
        check("t6_rst_pkt_done", pkt_done, 1'b0);
        check("t6_rst_rd_en", fifo_rd_en, 1'b0);
        model_reset();
        fifo_rd_empty = 1'b1;
        @(negedge clk);
        check("t6_rst_hold_tvalid", m_axis_tvalid, 1'b0);
        rst = 1'b0;
        tready_fixed = 1'b1;
        clear_log(); push_words(4);
        run_until_beats(4, 30, "t6_beats");
        run(2);
        pat = 8'd0;
        for (int i = 0; i < 4 && i < log_last.size(); i++) pat[i] = log_last[i];
        check("t6_restart_pattern", pat, 8'b0000_1000);
        check("t6_stat_pkt_cnt", stat_pkt_cnt, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
